// File: rtl/pc_fetch.sv
// Program counter and single-outstanding instruction fetch stage.
// Fetches over a req/ack handshake, holds the instruction until commit, then picks the next PC.
module pc_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned MAX_WAIT     = 16
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        PCSrc,
   input  logic [31:0] Result,
   input  logic        Busy,
   input  logic        IMemAck,
   input  logic [31:0] IMemRData,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic [31:0] PCPlus8,
   output logic [31:0] Instr,
   output logic        InstrValid,
   output logic        FetchErr
);

   localparam int unsigned CW        = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [31:0] ALIGN_MSK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_EXEC = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t         state, state_nxt;
   logic [31:0]    pc, pc_nxt;
   logic [31:0]    instr, instr_nxt;
   logic [CW-1:0]  wait_cnt, wait_nxt;

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= S_IDLE;
         pc       <= RESET_VECTOR;
         instr    <= 32'h0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         instr    <= instr_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // Next-state logic; an ack in the timeout cycle takes priority over the error
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      instr_nxt = instr;
      wait_nxt  = wait_cnt;
      case (state)
         S_IDLE: begin
            state_nxt = S_REQ;
            wait_nxt  = '0;
         end
         S_REQ: begin
            if (IMemAck) begin
               instr_nxt = IMemRData;
               state_nxt = S_EXEC;
            end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
               state_nxt = S_ERR;
            end else begin
               wait_nxt = wait_cnt + CW'(1);
            end
         end
         S_EXEC: begin
            if (!Busy) begin
               pc_nxt    = PCSrc ? (Result & ALIGN_MSK) : (pc + 32'd4);
               wait_nxt  = '0;
               state_nxt = S_REQ;
            end
         end
         S_ERR: begin
            state_nxt = S_ERR;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Moore outputs decoded from the state register
   always_comb begin
      IMemReq    = 1'b0;
      InstrValid = 1'b0;
      FetchErr   = 1'b0;
      case (state)
         S_REQ:   IMemReq    = 1'b1;
         S_EXEC:  InstrValid = 1'b1;
         S_ERR:   FetchErr   = 1'b1;
         default: ;
      endcase
   end

   assign IMemAddr = pc;
   assign PC       = pc;
   assign PCPlus4  = pc + 32'd4;
   assign PCPlus8  = pc + 32'd8;
   assign Instr    = instr;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch; a second instance covers the wrapping reset vector.
module tb_pc_fetch;

   localparam logic [31:0] XOR_K  = 32'hA5A5_0000;
   localparam logic [31:0] WRAP_V = 32'hFFFF_FFFC;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        PCSrc = 1'b0;
   logic [31:0] Result = 32'h0;
   logic        Busy = 1'b0;
   logic        IMemAck;
   logic [31:0] IMemRData;
   logic        IMemReq;
   logic [31:0] IMemAddr, PC, PCPlus4, PCPlus8, Instr;
   logic        InstrValid, FetchErr;

   logic        w_ack, w_req, w_valid, w_err;
   logic [31:0] w_rdata, w_addr, w_pc, w_plus4, w_plus8, w_instr;

   logic auto_ack = 1'b1;
   logic man_ack  = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   assign IMemAck   = auto_ack ? IMemReq : man_ack;
   assign IMemRData = IMemAddr ^ XOR_K;
   assign w_ack     = w_req;
   assign w_rdata   = w_addr ^ XOR_K;

   pc_fetch #(.RESET_VECTOR(32'h0), .MAX_WAIT(16)) dut (
      .CLK(CLK), .RESET(RESET), .PCSrc(PCSrc), .Result(Result), .Busy(Busy),
      .IMemAck(IMemAck), .IMemRData(IMemRData), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
      .PC(PC), .PCPlus4(PCPlus4), .PCPlus8(PCPlus8), .Instr(Instr),
      .InstrValid(InstrValid), .FetchErr(FetchErr)
   );

   pc_fetch #(.RESET_VECTOR(WRAP_V), .MAX_WAIT(16)) dut_w (
      .CLK(CLK), .RESET(RESET), .PCSrc(1'b0), .Result(32'h0), .Busy(1'b0),
      .IMemAck(w_ack), .IMemRData(w_rdata), .IMemReq(w_req), .IMemAddr(w_addr),
      .PC(w_pc), .PCPlus4(w_plus4), .PCPlus8(w_plus8), .Instr(w_instr),
      .InstrValid(w_valid), .FetchErr(w_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Request and valid must never overlap
   always @(negedge CLK) begin
      if (!RESET) check_eq("req_valid_excl", {31'b0, IMemReq & InstrValid}, 32'h0);
   end

   task automatic do_reset();
      RESET = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      check_eq("rst_req",   {31'b0, IMemReq},    32'h0);
      check_eq("rst_valid", {31'b0, InstrValid}, 32'h0);
      check_eq("rst_err",   {31'b0, FetchErr},   32'h0);
      check_eq("rst_pc",    PC,                  32'h0);
      check_eq("rst_instr", Instr,               32'h0);
      check_eq("rst_w_pc",  w_pc,                WRAP_V);
      RESET = 1'b0;
      Busy  = 1'b0;
      PCSrc = 1'b0;
   endtask

   task automatic step_req(input logic [31:0] exp_addr);
      @(negedge CLK);
      check_eq("req_high",  {31'b0, IMemReq},    32'h1);
      check_eq("req_addr",  IMemAddr,            exp_addr);
      check_eq("req_valid", {31'b0, InstrValid}, 32'h0);
      PCSrc = 1'b0;
   endtask

   task automatic step_exec(input logic [31:0] exp_pc, input logic br, input logic [31:0] tgt);
      @(negedge CLK);
      check_eq("exec_valid", {31'b0, InstrValid}, 32'h1);
      check_eq("exec_pc",    PC,                  exp_pc);
      check_eq("exec_instr", Instr,               exp_pc ^ XOR_K);
      check_eq("exec_req",   {31'b0, IMemReq},    32'h0);
      PCSrc  = br;
      Result = tgt;
   endtask

   initial begin
      int n;

      // Sequential fetch from 0, plus the wrapping instance
      do_reset();
      check_eq("w_plus4", w_plus4, 32'h0);
      check_eq("w_plus8", w_plus8, 32'h0000_0004);
      for (int k = 0; k < 4; k++) begin
         step_req(32'(k * 4));
         if (k == 0) check_eq("w_addr0", w_addr, WRAP_V);
         if (k == 1) check_eq("w_addr1", w_addr, 32'h0);
         step_exec(32'(k * 4), 1'b0, 32'h0);
         check_eq("plus4", PCPlus4, 32'(k * 4 + 4));
      end

      // Branch at PC=8 to 0x103 (low bits dropped)
      do_reset();
      step_req(32'h0); step_exec(32'h0, 1'b0, 32'h0);
      step_req(32'h4); step_exec(32'h4, 1'b0, 32'h0);
      step_req(32'h8); step_exec(32'h8, 1'b1, 32'h0000_0103);
      step_req(32'h100);
      step_exec(32'h100, 1'b0, 32'h0);
      check_eq("br_plus8", PCPlus8, 32'h0000_0108);

      // Stall with PCSrc toggling, then sequential release
      do_reset();
      step_req(32'h0); step_exec(32'h0, 1'b0, 32'h0);
      step_req(32'h4); step_exec(32'h4, 1'b0, 32'h0);
      Busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         check_eq("stall_pc",    PC,                  32'h4);
         check_eq("stall_instr", Instr,               32'h4 ^ XOR_K);
         check_eq("stall_valid", {31'b0, InstrValid}, 32'h1);
         check_eq("stall_req",   {31'b0, IMemReq},    32'h0);
         PCSrc  = i[0];
         Result = 32'h0000_0200;
      end
      Busy  = 1'b0;
      PCSrc = 1'b0;
      step_req(32'h8);

      // Reset in the middle of a stall
      step_exec(32'h8, 1'b0, 32'h0);
      Busy = 1'b1;
      @(negedge CLK);
      do_reset();
      step_req(32'h0);

      // Reset after three un-acked request cycles
      do_reset();
      auto_ack = 1'b0;
      man_ack  = 1'b0;
      for (int i = 0; i < 3; i++) step_req(32'h0);
      do_reset();
      auto_ack = 1'b1;
      step_req(32'h0);
      step_exec(32'h0, 1'b0, 32'h0);

      // Timeout: request held exactly 16 cycles, then sticky error
      do_reset();
      auto_ack = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (IMemReq) n++;
         if (FetchErr) break;
      end
      check_eq("to_req_cycles", 32'(n), 32'd16);
      check_eq("to_err", {31'b0, FetchErr}, 32'h1);
      for (int i = 0; i < 3; i++) begin
         man_ack = 1'b1;
         @(negedge CLK);
         check_eq("err_hold",  {31'b0, FetchErr},   32'h1);
         check_eq("err_req",   {31'b0, IMemReq},    32'h0);
         check_eq("err_valid", {31'b0, InstrValid}, 32'h0);
         check_eq("err_pc",    PC,                  32'h0);
      end
      man_ack = 1'b0;

      // Ack on the 16th waiting cycle wins over the timeout
      do_reset();
      check_eq("rst_clears_err", {31'b0, FetchErr}, 32'h0);
      for (int i = 1; i <= 16; i++) begin
         step_req(32'h0);
         if (i == 16) man_ack = 1'b1;
      end
      @(negedge CLK);
      man_ack = 1'b0;
      check_eq("late_ack_valid", {31'b0, InstrValid}, 32'h1);
      check_eq("late_ack_err",   {31'b0, FetchErr},   32'h0);
      check_eq("late_ack_instr", Instr,               XOR_K);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
Program-counter and instruction-fetch stage that sits upstream of the conditional-execution logic, and also consumes its PCSrc output.
- Holds the architectural PC and fetches one instruction at a time from a variable-latency instruction memory using a req/ack handshake.
- Presents the instruction to decode/execute until it commits.
- On commit, selects the next PC: either the sequential address or the Result-bus branch target when PCSrc is asserted.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (word aligned).
MAX_WAIT, 16, number of consecutive un-acked request cycles tolerated before a fetch error (>=1).

Ports:
CLK  input  1  system clock, all state updates on rising edge.
RESET  input  1  synchronous, active-high reset.
PCSrc  input  1  gated branch/PC-write enable from conditional logic.
Result  input  32  branch target / R15 write value.
Busy  input  1  execute-side stall (e.g. multi-cycle unit); 1 = do not commit.
IMemAck  input  1  instruction memory: read data valid this cycle.
IMemRData  input  32  instruction memory read data.
IMemReq  output  1  fetch request, level, held until ack.
IMemAddr  output  32  fetch address (= PC).
PC  output  32  current instruction address.
PCPlus4  output  32  PC+4, combinational.
PCPlus8  output  32  PC+8 (R15 read value), combinational.
Instr  output  32  latched instruction.
InstrValid  output  1  Instr is valid for decode/execute.
FetchErr  output  1  sticky memory-timeout error.

Behaviour:
- States:
  - S_IDLE: one cycle after reset.
  - S_REQ: fetching.
  - S_EXEC: instruction held.
  - S_ERR: dead until reset.
- Reset (RESET=1 at a clock edge, in any state, including mid-request or mid-stall):
  - state=S_IDLE, PC=RESET_VECTOR, Instr=0, wait counter=0, FetchErr=0.
  - Outputs: IMemReq=0, InstrValid=0.
  - Any ack arriving in the same cycle is discarded.
- S_IDLE -> S_REQ unconditionally. Wait counter is cleared on every entry to S_REQ.
- S_REQ:
  - IMemReq=1, IMemAddr=PC; both stable for the whole state.
  - IMemAck=1: Instr<=IMemRData, go to S_EXEC.
  - IMemAck=0: wait counter +1. If this is the MAX_WAIT-th consecutive un-acked cycle, go to S_ERR.
  - Ack in the same cycle as the timeout: ack wins, no error.
- S_EXEC:
  - InstrValid=1, IMemReq=0, Instr held.
  - Busy=1: hold everything; PCSrc and Result are ignored.
  - Busy=0 (commit): PC <= PCSrc ? {Result[31:2],2'b00} : PC+4, then go to S_REQ.
  - Result[1:0] are always ignored.
- S_ERR: FetchErr=1, IMemReq=0, InstrValid=0, PC frozen. Stays until RESET.
- PCSrc and Result are sampled only at commit. Outside S_EXEC with Busy=0 they have no effect.
- Arithmetic is modulo 2^32:
  - PC=32'hFFFF_FFFC with sequential commit -> next PC 32'h0000_0000.
  - PCPlus4 and PCPlus8 wrap the same way.
- Throughput: at best 2 cycles per instruction (1 S_REQ cycle with immediate ack + 1 S_EXEC cycle).
- IMemAck is ignored outside S_REQ (no buffering of stray acks).
- InstrValid and IMemReq are never both 1.

Test Plan:
1. Reset then immediate acks, RESET_VECTOR=0, PCSrc=0, Busy=0, mem returns addr^32'hA5A5_0000:
   - IMemAddr sequence 0,4,8,C on every other cycle.
   - Instr matches the returned data; InstrValid pulses 1 cycle each.
2. Branch: at PC=8 in S_EXEC, PCSrc=1, Result=32'h0000_0103:
   - Next IMemAddr=32'h0000_0100.
   - PCPlus8=32'h0000_0108 after fetch.
3. Stall: Busy=1 for 5 cycles in S_EXEC while PCSrc toggles:
   - PC, Instr and InstrValid=1 are unchanged; no IMemReq.
   - Release with PCSrc=0 -> PC+4.
4. Timeout, MAX_WAIT=16, no ack:
   - IMemReq high exactly 16 cycles, then FetchErr=1 and IMemReq=0, held until RESET.
   - Variant: ack on the 16th cycle -> no error.
5. Wrap: RESET_VECTOR=32'hFFFF_FFFC, sequential commit:
   - Next IMemAddr=0.
   - PCPlus8 from 32'hFFFF_FFFC = 32'h0000_0004.
6. Reset mid-wait and mid-stall: RESET during S_REQ (3 cycles un-acked) and during S_EXEC with Busy=1:
   - Next cycle all outputs are at reset values and PC=RESET_VECTOR.
   - Fetch restarts from RESET_VECTOR.
